// File: rtl/wb_write_sequencer.sv
// Write-back sequencer for the Y86-64 SEQ register file: issues up to two writes per retired record.
// Define WB_EXT_PORT_EN to let an external loader/debug writer use the port in IDLE/DONE cycles.
module wb_write_sequencer #(
  parameter int DATA_W = 64,
  parameter int RID_W  = 4,
  parameter int RSP_ID = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [RID_W-1:0]  rA,
  input  logic [RID_W-1:0]  rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [RID_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_done,
  input  logic              ext_req,
  input  logic [RID_W-1:0]  ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_gnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a record transfers on a rising edge where in_valid && in_ready.
  // in_ready is high only in IDLE and never depends on in_valid.
  typedef enum logic [1:0] {IDLE = 2'd0, WR_E = 2'd1, WR_M = 2'd2, DONE = 2'd3} state_t;

  localparam logic [RID_W-1:0] RNONE = '1;
  localparam logic [RID_W-1:0] RSP   = RID_W'(RSP_ID);

  state_t              state_q, state_d;
  logic [3:0]          icode_q, icode_d;
  logic                cnd_q, cnd_d;
  logic [RID_W-1:0]    ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0]   vale_q, vale_d, valm_q, valm_d;
  logic [RID_W-1:0]    waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  function automatic logic [RID_W-1:0] e_addr(input logic [3:0] ic, input logic [RID_W-1:0] rb);
    case (ic)
      4'h8, 4'h9, 4'hA, 4'hB: e_addr = RSP;
      default:                e_addr = rb;
    endcase
  endfunction

  function automatic logic e_write(input logic [3:0] ic, input logic c, input logic [RID_W-1:0] rb);
    case (ic)
      4'h2:                         e_write = c;
      4'h3, 4'h6:                   e_write = 1'b1;
      4'h8, 4'h9, 4'hA, 4'hB:       e_write = 1'b1;
      default:                      e_write = 1'b0;
    endcase
    if (e_addr(ic, rb) == RNONE) e_write = 1'b0;
  endfunction

  function automatic logic m_write(input logic [3:0] ic, input logic [RID_W-1:0] ra);
    m_write = ((ic == 4'h5) || (ic == 4'hB)) && (ra != RNONE);
  endfunction

  always_comb begin
    state_d  = state_q;
    icode_d  = icode_q;
    cnd_d    = cnd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    vale_d   = vale_q;
    valm_d   = valm_q;
    rf_we    = 1'b0;
    rf_waddr = waddr_q;
    rf_wdata = wdata_q;
    ext_gnt  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          icode_d = icode;
          cnd_d   = cnd;
          ra_d    = rA;
          rb_d    = rB;
          vale_d  = valE;
          valm_d  = valM;
          // Decode the incoming record now so its first write lands the very next cycle.
          if (e_write(icode, cnd, rB))   state_d = WR_E;
          else if (m_write(icode, rA))   state_d = WR_M;
          else                           state_d = DONE;
        end
      end
      WR_E: begin
        rf_we    = 1'b1;
        rf_waddr = e_addr(icode_q, rb_q);
        rf_wdata = vale_q;
        state_d  = m_write(icode_q, ra_q) ? WR_M : DONE;
      end
      WR_M: begin
        rf_we    = 1'b1;
        rf_waddr = ra_q;
        rf_wdata = valm_q;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef WB_EXT_PORT_EN
    if (ext_req && ((state_q == IDLE) || (state_q == DONE))) begin
      ext_gnt  = 1'b1;
      rf_we    = (ext_addr != RNONE);
      rf_waddr = ext_addr;
      rf_wdata = ext_data;
    end
`endif

    waddr_d = rf_we ? rf_waddr : waddr_q;
    wdata_d = rf_we ? rf_wdata : wdata_q;
  end

`ifndef WB_EXT_PORT_EN
  logic unused_ext;
  assign unused_ext = ^{ext_req, ext_addr, ext_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icode_q <= '0;
      cnd_q   <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      vale_q  <= '0;
      valm_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign wb_done   = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed bench for wb_write_sequencer: table of records with hand-computed write sequences,
// plus reset-abort and external-port sequences.
module tb_wb_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  icode = '0;
  logic        cnd = 1'b0;
  logic [3:0]  ra = '0, rb = '0;
  logic [63:0] vale = '0, valm = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_done;
  logic        ext_req = 1'b0;
  logic [3:0]  ext_addr = '0;
  logic [63:0] ext_data = '0;
  logic        ext_gnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  wb_write_sequencer #(.DATA_W(64), .RID_W(4), .RSP_ID(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .cnd(cnd), .rA(ra), .rB(rb), .valE(vale), .valM(valm),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_done(wb_done),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_data(ext_data), .ext_gnt(ext_gnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  ra, rb;
    logic [63:0] vale, valm;
    int          n;
    logic [3:0]  a0;
    logic [63:0] d0;
    logic [3:0]  a1;
    logic [63:0] d1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] ic, input logic c,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [63:0] e, input logic [63:0] m, input int n,
                              input logic [3:0] a0, input logic [63:0] d0,
                              input logic [3:0] a1, input logic [63:0] d1);
    vec_t v;
    v.name = name; v.icode = ic; v.cnd = c; v.ra = a; v.rb = b; v.vale = e; v.valm = m;
    v.n = n; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  // Presents one record at a negedge, then checks each following cycle against the expected writes.
  task automatic apply(input vec_t v);
    logic [3:0]  ea[2];
    logic [63:0] ed[2];
    ea[0] = v.a0; ea[1] = v.a1; ed[0] = v.d0; ed[1] = v.d1;
    @(negedge clk);
    chk({v.name, ".in_ready"}, 64'(in_ready), 64'd1);
    icode = v.icode; cnd = v.cnd; ra = v.ra; rb = v.rb; vale = v.vale; valm = v.valm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble the inputs after acceptance: the writes must come from the latched record.
    icode = 4'(($urandom_range(0, 15))); cnd = ~v.cnd;
    ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
    vale = {$urandom, $urandom}; valm = {$urandom, $urandom};
    for (int k = 0; k < v.n; k++) begin
      chk($sformatf("%s.w%0d.we", v.name, k), 64'(rf_we), 64'd1);
      chk($sformatf("%s.w%0d.addr", v.name, k), 64'(rf_waddr), 64'(ea[k]));
      chk($sformatf("%s.w%0d.data", v.name, k), rf_wdata, ed[k]);
      chk($sformatf("%s.w%0d.done", v.name, k), 64'(wb_done), 64'd0);
      chk($sformatf("%s.w%0d.gnt", v.name, k), 64'(ext_gnt), 64'd0);
      @(negedge clk);
    end
    chk({v.name, ".done"}, 64'(wb_done), 64'd1);
    chk({v.name, ".done_we"}, 64'(rf_we), 64'd0);
    chk({v.name, ".ready_in_done"}, 64'(in_ready), 64'd0);
    if (v.n > 0) begin
      chk({v.name, ".hold_addr"}, 64'(rf_waddr), 64'(ea[v.n-1]));
      chk({v.name, ".hold_data"}, rf_wdata, ed[v.n-1]);
    end
  endtask

  initial begin
    vecs.push_back(mk("irmovq",     4'h3, 1'b0, 4'hF, 4'h3, 64'd20,     64'd0,   1, 4'h3, 64'd20,     4'h0, 64'd0));
    vecs.push_back(mk("cmov_t",     4'h2, 1'b1, 4'hF, 4'h0, 64'd12,     64'd0,   1, 4'h0, 64'd12,     4'h0, 64'd0));
    vecs.push_back(mk("cmov_f",     4'h2, 1'b0, 4'hF, 4'h0, 64'd12,     64'd0,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("popq_r5",    4'hB, 1'b0, 4'h5, 4'hF, 64'd99,     64'd100, 2, 4'h4, 64'd99,     4'h5, 64'd100));
    vecs.push_back(mk("popq_rsp",   4'hB, 1'b0, 4'h4, 4'hF, 64'd99,     64'd100, 2, 4'h4, 64'd99,     4'h4, 64'd100));
    vecs.push_back(mk("mrmovq",     4'h5, 1'b0, 4'h2, 4'h6, 64'd7,      64'd15,  1, 4'h2, 64'd15,     4'h0, 64'd0));
    vecs.push_back(mk("mrmovq_rno", 4'h5, 1'b0, 4'hF, 4'h6, 64'd7,      64'd15,  0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("opq",        4'h6, 1'b0, 4'h1, 4'hA, 64'h1234,   64'd5,   1, 4'hA, 64'h1234,   4'h0, 64'd0));
    vecs.push_back(mk("call",       4'h8, 1'b0, 4'hF, 4'hF, 64'h80,     64'd5,   1, 4'h4, 64'h80,     4'h0, 64'd0));
    vecs.push_back(mk("ret",        4'h9, 1'b0, 4'hF, 4'hF, 64'h88,     64'h400, 1, 4'h4, 64'h88,     4'h0, 64'd0));
    vecs.push_back(mk("pushq",      4'hA, 1'b0, 4'h3, 4'hF, 64'h78,     64'd5,   1, 4'h4, 64'h78,     4'h0, 64'd0));
    vecs.push_back(mk("irmovq_rno", 4'h3, 1'b0, 4'hF, 4'hF, 64'd55,     64'd0,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("halt",       4'h0, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("nop",        4'h1, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("rmmovq",     4'h4, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("jxx",        4'h7, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("icode_c",    4'hC, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));
    vecs.push_back(mk("icode_f",    4'hF, 1'b1, 4'h1, 4'h2, 64'd1,      64'd2,   0, 4'h0, 64'd0,      4'h0, 64'd0));

    // Reset state.
    #12;
    chk("rst.we", 64'(rf_we), 64'd0);
    chk("rst.waddr", 64'(rf_waddr), 64'd0);
    chk("rst.wdata", rf_wdata, 64'd0);
    chk("rst.done", 64'(wb_done), 64'd0);
    chk("rst.gnt", 64'(ext_gnt), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef WB_EXT_PORT_EN
    // Without the external port a held request must never be granted or reach the port.
    ext_req = 1'b1; ext_addr = 4'h7; ext_data = 64'hAA;
`endif

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulled during the E-write of a popq: writes stop at once and the M-write never happens.
    @(negedge clk);
    icode = 4'hB; ra = 4'h5; rb = 4'hF; vale = 64'd99; valm = 64'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort.we_before", 64'(rf_we), 64'd1);
    chk("abort.addr_before", 64'(rf_waddr), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.we_async", 64'(rf_we), 64'd0);
    chk("abort.ready", 64'(in_ready), 64'd1);
    chk("abort.waddr", 64'(rf_waddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort.c%0d.we", k), 64'(rf_we), 64'd0);
      chk($sformatf("abort.c%0d.done", k), 64'(wb_done), 64'd0);
      chk($sformatf("abort.c%0d.ready", k), 64'(in_ready), 64'd1);
    end

`ifdef WB_EXT_PORT_EN
    // Held external request around a popq: granted in IDLE and DONE only.
    ext_req = 1'b1; ext_addr = 4'h7; ext_data = 64'hAA;
    #1;
    chk("ext.idle.gnt", 64'(ext_gnt), 64'd1);
    chk("ext.idle.we", 64'(rf_we), 64'd1);
    chk("ext.idle.addr", 64'(rf_waddr), 64'd7);
    chk("ext.idle.data", rf_wdata, 64'hAA);
    icode = 4'hB; ra = 4'h5; rb = 4'hF; vale = 64'd99; valm = 64'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ext.wre.gnt", 64'(ext_gnt), 64'd0);
    chk("ext.wre.addr", 64'(rf_waddr), 64'd4);
    chk("ext.wre.data", rf_wdata, 64'd99);
    @(negedge clk);
    chk("ext.wrm.gnt", 64'(ext_gnt), 64'd0);
    chk("ext.wrm.addr", 64'(rf_waddr), 64'd5);
    chk("ext.wrm.data", rf_wdata, 64'd100);
    @(negedge clk);
    chk("ext.done.pulse", 64'(wb_done), 64'd1);
    chk("ext.done.gnt", 64'(ext_gnt), 64'd1);
    chk("ext.done.addr", 64'(rf_waddr), 64'd7);
    ext_addr = 4'hF;
    #1;
    chk("ext.rnone.we", 64'(rf_we), 64'd0);
    ext_req = 1'b0;
    @(negedge clk);
    chk("ext.off.gnt", 64'(ext_gnt), 64'd0);
`else
    @(negedge clk);
    chk("noext.gnt", 64'(ext_gnt), 64'd0);
    chk("noext.we", 64'(rf_we), 64'd0);
    ext_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
